// File: rtl/pipe_if_stage.sv
// pipe_if_stage: instruction fetch stage with IF/ID register, stall hold buffer and interrupt entry.
module pipe_if_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  pcsource,
   input  logic [31:0] bpc,
   input  logic [31:0] rpc,
   input  logic [31:0] jpc,
   input  logic        nostall,
   input  logic        intr,
   input  logic        ie,
   input  logic        irdy,
   input  logic [31:0] idata,
   output logic [31:0] iaddr,
   output logic        ireq,
   output logic [31:0] pc,
   output logic [31:0] dpc4,
   output logic [31:0] inst,
   output logic        inta,
   output logic [31:0] epc
);
   typedef enum logic {FETCH, HOLD} state_t;
   state_t state, state_nx;
   logic [31:0] buffer, pc4, npc;
   logic adv, take, park;
   always_comb begin
      pc4      = pc + 32'd4;
      npc      = pcsource == 2'b00 ? pc4 : pcsource == 2'b01 ? bpc : pcsource == 2'b10 ? rpc : jpc;
      adv      = nostall & (state == HOLD | irdy);
      park     = state == FETCH & irdy & ~nostall;
      // interrupts only replace sequential fetches, so a delay slot is never lost
      take     = adv & intr & ie & pcsource == 2'b00;
      inta     = take & ~rst;
      ireq     = state == FETCH & ~rst;
      iaddr    = pc;
      state_nx = park ? HOLD : (state == HOLD & nostall) ? FETCH : state;
   end
   always_ff @(posedge clk)
      if (rst) state <= FETCH;
      else state <= state_nx;
   always_ff @(posedge clk) begin
      if (rst) begin
         pc     <= '0;
         inst   <= '0;
         dpc4   <= '0;
         epc    <= '0;
         buffer <= '0;
      end else begin
         if (park) buffer <= idata;
         if (take) begin
            inst <= '0;
            epc  <= pc;
            pc   <= 32'h0000_0008;
         end else if (adv) begin
            inst <= state == HOLD ? buffer : idata;
            dpc4 <= pc4;
            pc   <= npc;
         end else if (nostall) inst <= '0;
      end
   end
endmodule

// File: tb/tb_pipe_if_stage.sv
// tb_pipe_if_stage: directed table, hand sequences and random stimulus against a behavioural fetch model.
module tb_pipe_if_stage;
   logic clk = 0, rst, nostall, intr, ie, irdy, inta, ireq;
   logic [1:0] pcsource;
   logic [31:0] bpc, rpc, jpc, idata, iaddr, pc, dpc4, inst, epc;
   int checks = 0, errors = 0;

   pipe_if_stage dut (.clk(clk), .rst(rst), .pcsource(pcsource), .bpc(bpc), .rpc(rpc), .jpc(jpc),
      .nostall(nostall), .intr(intr), .ie(ie), .irdy(irdy), .idata(idata), .iaddr(iaddr),
      .ireq(ireq), .pc(pc), .dpc4(dpc4), .inst(inst), .inta(inta), .epc(epc));

   always #5 clk = ~clk;

   typedef struct {
      logic rst; logic [1:0] ps; logic ns, it, ie, rdy;
      logic [31:0] d, b, r, j;
      logic [31:0] e_pc, e_inst, e_dpc4, e_epc; logic e_inta, e_ireq;
   } vec_t;

   logic [31:0] m_pc = 0, m_inst = 0, m_dpc4 = 0, m_epc = 0, m_buf = 0;
   logic m_hold = 0;
   logic last_inta, last_ireq;

   function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", n, a, e);
      end
   endfunction

   task automatic apply(input vec_t v);
      logic [31:0] tgt [4];
      logic ready, go, irq;
      rst = v.rst; pcsource = v.ps; nostall = v.ns; intr = v.it; ie = v.ie; irdy = v.rdy;
      idata = v.d; bpc = v.b; rpc = v.r; jpc = v.j;
      ready = m_hold | irdy;
      go    = nostall & ready;
      irq   = go & intr & ie & pcsource == 2'b00;
      @(negedge clk);
      last_inta = inta; last_ireq = ireq;
      chk("inta", {31'b0, inta}, {31'b0, irq & ~rst});
      chk("ireq", {31'b0, ireq}, {31'b0, ~m_hold & ~rst});
      if (!rst) chk("iaddr", iaddr, m_pc);
      @(posedge clk);
      tgt[0] = m_pc + 4; tgt[1] = bpc; tgt[2] = rpc; tgt[3] = jpc;
      if (rst) begin
         m_pc = 0; m_inst = 0; m_dpc4 = 0; m_epc = 0; m_buf = 0; m_hold = 0;
      end else if (irq) begin
         m_epc = m_pc; m_pc = 32'h8; m_inst = 0; m_hold = 0;
      end else if (go) begin
         m_inst = m_hold ? m_buf : idata; m_dpc4 = m_pc + 4; m_pc = tgt[pcsource]; m_hold = 0;
      end else if (nostall) m_inst = 0;
      else if (irdy && !m_hold) begin
         m_hold = 1; m_buf = idata;
      end
      #1;
      chk("pc", pc, m_pc);
      chk("inst", inst, m_inst);
      chk("dpc4", dpc4, m_dpc4);
      chk("epc", epc, m_epc);
   endtask

   function automatic vec_t mk(logic r, logic [1:0] ps, logic ns, logic it, logic ien, logic rdy,
                               logic [31:0] d, logic [31:0] b, logic [31:0] rr, logic [31:0] j);
      vec_t v;
      v.rst = r; v.ps = ps; v.ns = ns; v.it = it; v.ie = ien; v.rdy = rdy;
      v.d = d; v.b = b; v.r = rr; v.j = j;
      v.e_pc = 0; v.e_inst = 0; v.e_dpc4 = 0; v.e_epc = 0; v.e_inta = 0; v.e_ireq = 0;
      return v;
   endfunction

   function automatic vec_t ex(vec_t v, logic [31:0] p, logic [31:0] i, logic [31:0] d4,
                               logic [31:0] e, logic a, logic q);
      vec_t w = v;
      w.e_pc = p; w.e_inst = i; w.e_dpc4 = d4; w.e_epc = e; w.e_inta = a; w.e_ireq = q;
      return w;
   endfunction

   vec_t tbl [14];
   vec_t v;

   initial begin
      tbl[0]  = ex(mk(1, 0, 1, 1, 1, 1, 32'h5, 0, 0, 0),          0,    0,    0,     0,    0, 0);
      tbl[1]  = ex(mk(0, 0, 1, 0, 0, 1, 32'h11, 0, 0, 0),         4,    'h11, 4,     0,    0, 1);
      tbl[2]  = ex(mk(0, 0, 1, 0, 0, 1, 32'h22, 0, 0, 0),         8,    'h22, 8,     0,    0, 1);
      tbl[3]  = ex(mk(0, 0, 1, 0, 0, 1, 32'h33, 0, 0, 0),         'hC,  'h33, 'hC,   0,    0, 1);
      tbl[4]  = ex(mk(0, 3, 1, 0, 0, 1, 32'h44, 0, 0, 'h40),      'h40, 'h44, 'h10,  0,    0, 1);
      tbl[5]  = ex(mk(0, 1, 1, 0, 0, 1, 32'h55, 'h100, 0, 0),     'h100,'h55, 'h44,  0,    0, 1);
      tbl[6]  = ex(mk(0, 2, 1, 0, 0, 1, 32'h66, 0, 'h20, 0),      'h20, 'h66, 'h104, 0,    0, 1);
      tbl[7]  = ex(mk(0, 0, 1, 1, 1, 1, 32'h77, 0, 0, 0),         8,    0,    'h104, 'h20, 1, 1);
      tbl[8]  = ex(mk(0, 3, 1, 1, 1, 1, 32'h88, 0, 0, 'h80),      'h80, 'h88, 'hC,   'h20, 0, 1);
      tbl[9]  = ex(mk(0, 0, 1, 1, 1, 1, 32'h99, 0, 0, 0),         8,    0,    'hC,   'h80, 1, 1);
      tbl[10] = ex(mk(0, 0, 1, 0, 1, 1, 32'hAA, 0, 0, 0),         'hC,  'hAA, 'hC,   'h80, 0, 1);
      tbl[11] = ex(mk(0, 0, 1, 0, 0, 0, 32'hBB, 0, 0, 0),         'hC,  0,    'hC,   'h80, 0, 1);
      tbl[12] = ex(mk(0, 0, 0, 0, 0, 0, 32'hCC, 0, 0, 0),         'hC,  0,    'hC,   'h80, 0, 1);
      tbl[13] = ex(mk(0, 0, 1, 1, 0, 1, 32'hDD, 0, 0, 0),         'h10, 'hDD, 'h10,  'h80, 0, 1);
      for (int i = 0; i < 14; i++) begin
         apply(tbl[i]);
         chk($sformatf("tbl%0d_pc", i), pc, tbl[i].e_pc);
         chk($sformatf("tbl%0d_inst", i), inst, tbl[i].e_inst);
         chk($sformatf("tbl%0d_dpc4", i), dpc4, tbl[i].e_dpc4);
         chk($sformatf("tbl%0d_epc", i), epc, tbl[i].e_epc);
         chk($sformatf("tbl%0d_inta", i), {31'b0, last_inta}, {31'b0, tbl[i].e_inta});
         chk($sformatf("tbl%0d_ireq", i), {31'b0, last_ireq}, {31'b0, tbl[i].e_ireq});
      end
      // stall with a word in flight: captured once, delivered when ID releases
      for (int i = 0; i < 3; i++) begin
         apply(mk(0, 0, 0, 0, 0, 1, (i == 0) ? 32'hABCD : 32'h1234, 0, 0, 0));
         chk("hold_pc", pc, 32'h10);
      end
      apply(mk(0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0));
      chk("hold_ireq", {31'b0, last_ireq}, 32'h0);
      apply(mk(0, 0, 1, 0, 0, 0, 32'h0, 0, 0, 0));
      chk("hold_inst", inst, 32'hABCD);
      chk("hold_pc4", pc, 32'h14);
      // PC wrap at the top of the address space
      apply(mk(0, 3, 1, 0, 0, 1, 32'h1, 0, 0, 32'hFFFF_FFFC));
      chk("wrap_pre", pc, 32'hFFFF_FFFC);
      apply(mk(0, 0, 1, 0, 0, 1, 32'h2, 0, 0, 0));
      chk("wrap_pc", pc, 32'h0);
      chk("wrap_dpc4", dpc4, 32'h0);
      // reset while parked in HOLD with everything else active
      apply(mk(0, 0, 1, 0, 0, 1, 32'h3, 0, 0, 0));
      apply(mk(0, 0, 0, 0, 0, 1, 32'h4, 0, 0, 0));
      apply(mk(1, 0, 1, 1, 1, 1, 32'h5, 0, 0, 0));
      chk("rst_pc", pc, 0); chk("rst_inst", inst, 0); chk("rst_dpc4", dpc4, 0); chk("rst_epc", epc, 0);
      chk("rst_inta", {31'b0, last_inta}, 0); chk("rst_ireq", {31'b0, last_ireq}, 0);
      apply(mk(0, 0, 1, 0, 0, 1, 32'h6, 0, 0, 0));
      chk("first_fetch", {31'b0, last_ireq}, 1);
      for (int i = 0; i < 600; i++) begin
         v = mk($urandom_range(0, 49) == 0, 2'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
                $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
                $urandom, $urandom & ~32'h3, $urandom & ~32'h3, $urandom & ~32'h3);
         apply(v);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/pipe_if_stage.md
PIPE_IF_STAGE -- requirements
Module: pipe_if_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 pcsource  in  2  next-PC select from ID: 00 pc+4, 01 bpc, 10 rpc (jr), 11 jpc.
REQ-005 bpc, rpc, jpc  in  32 each  branch, register-jump and jump targets from ID.
REQ-006 nostall  in  1  0 = ID stalls; hold PC and the IF/ID register.
REQ-007 intr  in  1  level interrupt request; ie  in  1  interrupt enable.
REQ-008 irdy  in  1  instruction memory data valid; idata  in  32  fetched word.
REQ-009 iaddr  out  32  fetch address (equals pc); ireq  out  1  fetch request.
REQ-010 pc  out  32  current fetch PC.
REQ-011 dpc4  out  32  IF/ID PC+4; inst  out  32  IF/ID instruction.
REQ-012 inta  out  1  one-cycle interrupt acknowledge; epc  out  32  saved interrupt return PC.

Function
REQ-013 FSM states SHALL be FETCH and HOLD; ireq = 1 only in FETCH and not during rst.
REQ-014 npc SHALL be the pcsource-selected value; pc+4 wraps modulo 2^32 (0xFFFF_FFFC + 4 = 0).
REQ-015 Advance (FETCH, irdy=1, nostall=1) SHALL load inst<=idata, dpc4<=pc+4, pc<=npc.
REQ-016 FETCH, irdy=0, nostall=1 SHALL load inst<=0 (nop bubble), keep dpc4 and pc.
REQ-017 FETCH, irdy=1, nostall=0 SHALL capture idata in a 32-bit buffer and go to HOLD; pc, inst, dpc4 are held.
REQ-018 FETCH, irdy=0, nostall=0 SHALL hold pc, inst and dpc4.
REQ-019 HOLD, nostall=1 SHALL load inst<=buffer, dpc4<=pc+4, pc<=npc and return to FETCH; irdy is ignored in HOLD.
REQ-020 HOLD, nostall=0 SHALL hold all state.
REQ-021 Branch/jump targets SHALL take effect only on an advance; the instruction fetched in that advance (delay slot) is delivered unmodified.
REQ-022 An interrupt SHALL be taken on an advance (FETCH or HOLD) when intr=1, ie=1 and pcsource=00.
REQ-023 On an interrupt: inst<=0, dpc4 unchanged, epc<=pc (the discarded instruction), pc<=0x0000_0008, inta=1 for that cycle.
REQ-024 intr with pcsource!=00 SHALL defer to the next qualifying advance, so a delay slot is never discarded.
REQ-025 inta SHALL be combinational from the REQ-022 condition and 0 in all other cycles.
REQ-026 epc SHALL change only on an interrupt.
REQ-027 Latency: an instruction appears on inst one clock after its advance edge.

Reset
REQ-028 rst=1 SHALL force pc=0, inst=0, dpc4=0, epc=0, FSM=FETCH, buffer=0, ireq=0 and inta=0.
REQ-029 rst SHALL override every concurrent event, including HOLD, irdy and intr.
REQ-030 The first fetch SHALL request iaddr=0 in the first cycle after rst falls.

Verification
REQ-031 Reset, then irdy=1, nostall=1 and idata 0x11,0x22,0x33 -> pc 0,4,8,C; inst 0x11,0x22,0x33; dpc4 4,8,C.
REQ-032 pc=0x40 with pcsource=01, bpc=0x100 on an advance -> delay-slot word delivered, next pc=0x100, dpc4=0x44.
REQ-033 irdy=1 while nostall=0 for 3 cycles, idata=0xABCD -> HOLD, ireq=0, pc held; on nostall=1: inst=0xABCD, pc+=4.
REQ-034 pc=0x20, intr=ie=1, pcsource=00 on an advance -> inta one cycle, epc=0x20, pc=0x8, inst=0.
REQ-035 intr=ie=1 with pcsource=11 (jpc=0x80) -> no inta; next advance at pc=0x80 -> inta, epc=0x80.
REQ-036 pc=0xFFFF_FFFC advance with pcsource=00 -> pc=0, dpc4=0; rst asserted in HOLD -> all REQ-028 values next cycle.
